menu_ctl: RTL

- Top-level screen sequencer for the game's VGA pipeline.
- Takes synchronized button levels and a game-over event, and runs the MENU / PLAY / PAUSE / GAME_OVER state machine.
- Tracks the highlighted menu item and drives the screen-select code for the downstream vga_if stream mux.
- The screen-select code changes only at frame boundaries, so the screen never tears mid-frame.

---
 rtl/menu_if.sv | 26 ++
 rtl/menu_ctl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/menu_if.sv
// Button/frame inputs and screen-control outputs between the game top and menu_ctl.
interface menu_if;
    logic       vblnk;
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       btn_esc;
    logic       game_over;
    logic [1:0] screen_sel;
    logic [1:0] menu_item;
    logic       item_strobe;
    logic       game_start;
    logic       game_abort;
    logic       game_run;
    logic       paused;

    modport master (
        output vblnk, btn_up, btn_down, btn_enter, btn_esc, game_over,
        input  screen_sel, menu_item, item_strobe, game_start, game_abort, game_run, paused
    );

    modport slave (
        input  vblnk, btn_up, btn_down, btn_enter, btn_esc, game_over,
        output screen_sel, menu_item, item_strobe, game_start, game_abort, game_run, paused
    );
endinterface

// File: rtl/menu_ctl.sv
// Screen sequencer: MENU / PLAY / PAUSE / GAME_OVER with menu navigation, auto-repeat
// and frame-aligned screen selection for the VGA stream mux.
module menu_ctl #(
    parameter int unsigned MENU_ITEMS      = 3,
    parameter int unsigned REPEAT_FRAMES   = 15,
    parameter int unsigned GAMEOVER_FRAMES = 180
) (
    input  logic  clk,
    input  logic  rst,
    menu_if.slave bus
);
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DN    = 1;
    localparam int unsigned BTN_ENTER = 2;
    localparam int unsigned BTN_ESC   = 3;
    localparam logic [1:0]       ITEM_LAST = 2'(MENU_ITEMS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LIM  = CNT_W'(GAMEOVER_FRAMES);

    // Encoding doubles as the screen-select code.
    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       menu_item_q, menu_item_d;
    logic [1:0]       screen_sel_q, screen_sel_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] over_cnt_q, over_cnt_d;
    logic [3:0]       btn_q, btn_d;
    logic             vblnk_q, vblnk_d;
    logic             item_strobe_q, item_strobe_d;
    logic             game_start_q, game_start_d;
    logic             game_abort_q, game_abort_d;
    logic             game_run_q, game_run_d;
    logic             paused_q, paused_d;

    logic [3:0]       press;
    logic             frame_tick;
    logic             step_up;
    logic             step_dn;

    always_comb begin
        btn_d      = {bus.btn_esc, bus.btn_enter, bus.btn_down, bus.btn_up};
        vblnk_d    = bus.vblnk;
        frame_tick = vblnk_d & ~vblnk_q;
        press      = btn_d & ~btn_q;

        state_d       = state_q;
        menu_item_d   = menu_item_q;
        rep_cnt_d     = '0;
        over_cnt_d    = '0;
        item_strobe_d = 1'b0;
        game_start_d  = 1'b0;
        game_abort_d  = 1'b0;
        step_up       = 1'b0;
        step_dn       = 1'b0;
        screen_sel_d  = frame_tick ? 2'(state_q) : screen_sel_q;

        unique case (state_q)
            ST_MENU: begin
                if (press[BTN_ENTER]) begin
                    if (menu_item_q == 2'd0) begin
                        state_d      = ST_PLAY;
                        game_start_d = 1'b1;
                    end else begin
                        item_strobe_d = 1'b1;
                    end
                end else if (press[BTN_UP] != press[BTN_DN]) begin
                    step_up = press[BTN_UP];
                    step_dn = press[BTN_DN];
                end
                // Auto-repeat only runs while exactly one direction is held with no new edge.
                if ((press == 4'd0) && (btn_d[BTN_UP] ^ btn_d[BTN_DN])) begin
                    if (!frame_tick) begin
                        rep_cnt_d = rep_cnt_q;
                    end else if (rep_cnt_q >= REP_LAST) begin
                        step_up = btn_d[BTN_UP];
                        step_dn = btn_d[BTN_DN];
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
                end
                if (step_up) begin
                    menu_item_d = (menu_item_q == 2'd0) ? ITEM_LAST : menu_item_q - 2'd1;
                end else if (step_dn) begin
                    menu_item_d = (menu_item_q == ITEM_LAST) ? 2'd0 : menu_item_q + 2'd1;
                end
            end
            ST_PLAY: begin
                if (bus.game_over) begin
                    state_d = ST_OVER;
                end else if (press[BTN_ESC]) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press[BTN_ESC]) begin
                    state_d = ST_PLAY;
                end else if (press[BTN_ENTER]) begin
                    state_d      = ST_MENU;
                    game_abort_d = 1'b1;
                    menu_item_d  = 2'd0;
                end
            end
            ST_OVER: begin
                over_cnt_d = (frame_tick && (over_cnt_q != '1)) ? over_cnt_q + CNT_W'(1) : over_cnt_q;
                // Enter only skips once a frame has passed, so a press carried over from PLAY is ignored.
                if ((over_cnt_q >= OVER_LIM) || (press[BTN_ENTER] && (over_cnt_q != '0))) begin
                    state_d     = ST_MENU;
                    menu_item_d = 2'd0;
                end
            end
        endcase

        game_run_d = (state_d == ST_PLAY);
        paused_d   = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_MENU;
            menu_item_q   <= 2'd0;
            screen_sel_q  <= 2'd0;
            rep_cnt_q     <= '0;
            over_cnt_q    <= '0;
            btn_q         <= 4'hF;
            vblnk_q       <= 1'b1;
            item_strobe_q <= 1'b0;
            game_start_q  <= 1'b0;
            game_abort_q  <= 1'b0;
            game_run_q    <= 1'b0;
            paused_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            menu_item_q   <= menu_item_d;
            screen_sel_q  <= screen_sel_d;
            rep_cnt_q     <= rep_cnt_d;
            over_cnt_q    <= over_cnt_d;
            btn_q         <= btn_d;
            vblnk_q       <= vblnk_d;
            item_strobe_q <= item_strobe_d;
            game_start_q  <= game_start_d;
            game_abort_q  <= game_abort_d;
            game_run_q    <= game_run_d;
            paused_q      <= paused_d;
        end
    end

    assign bus.screen_sel  = screen_sel_q;
    assign bus.menu_item   = menu_item_q;
    assign bus.item_strobe = item_strobe_q;
    assign bus.game_start  = game_start_q;
    assign bus.game_abort  = game_abort_q;
    assign bus.game_run    = game_run_q;
    assign bus.paused      = paused_q;
endmodule
